aes_round_pipe: RTL

Pipelined, parametrised AES round datapath. Per transaction it applies ShiftRows, true GF(2^8) MixColumns (skippable for the final round) and AddRoundKey to a 128-bit post-SubBytes state. It uses a valid/ready handshake, a configurable pipeline depth and a sideband tag. It sits between the S-box stage and the round-state register of the iterative AES core, and supersedes the combinational round block.

---
 rtl/aes_pkg.sv | 43 ++++
 rtl/aes_mixcol.sv | 46 ++++
 rtl/aes_round_pipe.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// aes_pkg
//   Shared AES round constants and GF(2^8) helpers.
//   - AES_POLY      : reduction polynomial x^8+x^4+x^3+x+1 (0x11B)
//   - MC_FWD_COEF   : MixColumns circulant row {02,03,01,01}
//   - MC_INV_COEF   : InvMixColumns circulant row {0E,0B,0D,09}
//   - xtime / gmul  : GF(2^8) doubling and general multiply
//   - mc_coef       : picks circulant coefficient k (mod 4) from a packed row
//   - byte_lsb      : bit offset of byte s(r,c) in the column-major 128-bit state
package aes_pkg;

  localparam logic [8:0]  AES_POLY    = 9'h11B;
  localparam logic [31:0] MC_FWD_COEF = 32'h02030101;
  localparam logic [31:0] MC_INV_COEF = 32'h0E0B0D09;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY[7:0] : 8'h00);
  endfunction

  // Shift-and-add multiply; with a constant b this folds to a small XOR tree.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] mc_coef(input logic [31:0] coefs, input int k);
    int i;
    i = k & 3;
    return coefs[31-8*i -: 8];
  endfunction

  // s(0,0) sits in [127:120], s(1,0) in [119:112], ... s(3,3) in [7:0].
  function automatic int byte_lsb(input int r, input int c);
    return 120 - 8 * (4 * c + r);
  endfunction

endpackage

// File: rtl/aes_mixcol.sv
// aes_mixcol
//   MixColumns on one 32-bit column ([31:24] = row 0).
//   Optional macro AES_ROUND_INV_EN adds the inv select (InvMixColumns);
//   without it only the forward matrix is built.
// Ports:
//   col_in  : input column
//   inv     : (AES_ROUND_INV_EN only) 1 = InvMixColumns
//   col_out : mixed column
module aes_mixcol
  import aes_pkg::*;
(
  input  logic [31:0] col_in,
`ifdef AES_ROUND_INV_EN
  input  logic        inv,
`endif
  output logic [31:0] col_out
);

  // Row r of the circulant: out_r = sum_j coef[(j - r) mod 4] * a_j.
  // Coefficients are always constants here so each gmul folds to XORs.
  function automatic logic [31:0] mix(input logic [31:0] col, input logic [31:0] coefs);
    logic [31:0] res;
    logic [7:0]  acc;
    res = '0;
    for (int r = 0; r < 4; r++) begin
      acc = '0;
      for (int j = 0; j < 4; j++) begin
        acc = acc ^ gmul(col[31-8*j -: 8], mc_coef(coefs, j - r));
      end
      res[31-8*r -: 8] = acc;
    end
    return res;
  endfunction

  logic [31:0] col_fwd;
  assign col_fwd = mix(col_in, MC_FWD_COEF);

`ifdef AES_ROUND_INV_EN
  logic [31:0] col_inv;
  assign col_inv = mix(col_in, MC_INV_COEF);
  assign col_out = inv ? col_inv : col_fwd;
`else
  assign col_out = col_fwd;
`endif

endmodule

// File: rtl/aes_round_pipe.sv
// aes_round_pipe
//   Pipelined AES round: ShiftRows, MixColumns (skipped when last) and
//   AddRoundKey on a post-SubBytes 128-bit state, with a sideband tag.
//   Optional macro AES_ROUND_INV_EN enables the inverse round selected by
//   in_inv; when undefined in_inv is ignored and no inverse logic exists.
// Parameters:
//   PIPE_STAGES : register stages from accept to output (1..3)
//   TAG_W       : sideband tag width
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid/in_ready   : input handshake
//   in_state, in_key    : state and round key, column-major bytes
//   in_last, in_inv     : final round / inverse round
//   in_tag              : opaque tag returned with the result
//   out_valid/out_ready : output handshake
//   out_state, out_tag  : round result and its tag
//   occ                 : number of blocks held in the pipe
//
// Handshake: a block moves on a cycle where valid && ready are both high.
// All stages shift together when adv = out_ready || !out_valid; in_ready is
// adv, so it never depends on in_valid. Bubbles are not collapsed, and while
// out_valid && !out_ready every register holds.
//
// Stage split: the front half does ShiftRows + MixColumns (the inverse round
// also folds its key add in here, ahead of InvMixColumns); the back half adds
// the forward key. PIPE_STAGES=1 merges both halves into one register,
// PIPE_STAGES=3 adds an input register in front.
module aes_round_pipe
  import aes_pkg::*;
#(
  parameter int PIPE_STAGES = 2,
  parameter int TAG_W       = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [127:0]                       in_state,
  input  logic [127:0]                       in_key,
  input  logic                               in_last,
  input  logic                               in_inv,
  input  logic [TAG_W-1:0]                   in_tag,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [127:0]                       out_state,
  output logic [TAG_W-1:0]                   out_tag,
  output logic [$clog2(PIPE_STAGES+1)-1:0]   occ
);

  localparam int OCC_W = $clog2(PIPE_STAGES + 1);

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[byte_lsb(r, c) +: 8] = s[byte_lsb(r, (c + r) % 4) +: 8];
    return o;
  endfunction

`ifdef AES_ROUND_INV_EN
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[byte_lsb(r, c) +: 8] = s[byte_lsb(r, (c - r + 4) % 4) +: 8];
    return o;
  endfunction
`endif

  logic adv;
  logic accept;
  logic emit;

  assign adv      = out_ready || !out_valid;
  assign in_ready = adv;
  assign accept   = in_valid && adv;
  assign emit     = out_valid && out_ready;

  // ---------------------------------------------------------------- front
  logic             src_valid;
  logic [127:0]     src_state;
  logic [127:0]     src_key;
  logic             src_last;
  logic [TAG_W-1:0] src_tag;
`ifdef AES_ROUND_INV_EN
  logic             src_inv;
`else
  logic             unused_inv;
  assign unused_inv = in_inv;
`endif

  if (PIPE_STAGES == 3) begin : g_in_reg
    logic             v_q;
    logic [127:0]     s_q;
    logic [127:0]     k_q;
    logic             l_q;
    logic [TAG_W-1:0] t_q;
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        s_q <= '0;
        k_q <= '0;
        l_q <= 1'b0;
        t_q <= '0;
      end else if (adv) begin
        v_q <= accept;
        s_q <= in_state;
        k_q <= in_key;
        l_q <= in_last;
        t_q <= in_tag;
      end
    end
    assign src_valid = v_q;
    assign src_state = s_q;
    assign src_key   = k_q;
    assign src_last  = l_q;
    assign src_tag   = t_q;
`ifdef AES_ROUND_INV_EN
    logic i_q;
    always_ff @(posedge clk) begin
      if (!rst_n)   i_q <= 1'b0;
      else if (adv) i_q <= in_inv;
    end
    assign src_inv = i_q;
`endif
  end else begin : g_in_pass
    assign src_valid = accept;
    assign src_state = in_state;
    assign src_key   = in_key;
    assign src_last  = in_last;
    assign src_tag   = in_tag;
`ifdef AES_ROUND_INV_EN
    assign src_inv   = in_inv;
`endif
  end

  logic [127:0] mc_in;
  logic [127:0] mc_out;
  logic [127:0] a_state;

  always_comb begin
    mc_in = shift_rows(src_state);
`ifdef AES_ROUND_INV_EN
    // Inverse round adds the key before InvMixColumns.
    if (src_inv) mc_in = inv_shift_rows(src_state) ^ src_key;
`endif
  end

  for (genvar c = 0; c < 4; c++) begin : g_mixcol
    aes_mixcol u_mixcol (
      .col_in  (mc_in[127-32*c -: 32]),
`ifdef AES_ROUND_INV_EN
      .inv     (src_inv),
`endif
      .col_out (mc_out[127-32*c -: 32])
    );
  end

  assign a_state = src_last ? mc_in : mc_out;

  // ---------------------------------------------------------------- middle
  logic             mid_valid;
  logic [127:0]     mid_state;
  logic [127:0]     mid_key;
  logic [TAG_W-1:0] mid_tag;
`ifdef AES_ROUND_INV_EN
  logic             mid_inv;
`endif

  if (PIPE_STAGES == 1) begin : g_mid_pass
    assign mid_valid = src_valid;
    assign mid_state = a_state;
    assign mid_key   = src_key;
    assign mid_tag   = src_tag;
`ifdef AES_ROUND_INV_EN
    assign mid_inv   = src_inv;
`endif
  end else begin : g_mid_reg
    logic             v_q;
    logic [127:0]     s_q;
    logic [127:0]     k_q;
    logic [TAG_W-1:0] t_q;
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        s_q <= '0;
        k_q <= '0;
        t_q <= '0;
      end else if (adv) begin
        v_q <= src_valid;
        s_q <= a_state;
        k_q <= src_key;
        t_q <= src_tag;
      end
    end
    assign mid_valid = v_q;
    assign mid_state = s_q;
    assign mid_key   = k_q;
    assign mid_tag   = t_q;
`ifdef AES_ROUND_INV_EN
    logic i_q;
    always_ff @(posedge clk) begin
      if (!rst_n)   i_q <= 1'b0;
      else if (adv) i_q <= src_inv;
    end
    assign mid_inv = i_q;
`endif
  end

  // ---------------------------------------------------------------- back
  logic [127:0] b_state;

  always_comb begin
    b_state = mid_state ^ mid_key;
`ifdef AES_ROUND_INV_EN
    // Inverse key was already added in the front half.
    if (mid_inv) b_state = mid_state;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_state <= '0;
      out_tag   <= '0;
    end else if (adv) begin
      out_valid <= mid_valid;
      out_state <= b_state;
      out_tag   <= mid_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                occ <= '0;
    else if (accept && !emit)  occ <= occ + OCC_W'(1);
    else if (!accept && emit)  occ <= occ - OCC_W'(1);
  end

endmodule
